// File: rtl/dequant_pkg.sv
// dequant_pkg: shared FSM states and fp32 constants for the dequant scheduler
package dequant_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ISSUE} state_e;
  typedef logic [31:0] fp32_t;
  localparam fp32_t FP32_ONE  = 32'h3F800000;
  localparam fp32_t FP32_ZERO = 32'h00000000;
endpackage

// File: rtl/dequant_sched_dequant.sv
// dequant: unsigned int8 lane times fp32 scale (truncating), saturated to a positive nonzero amax
module dequant
  import dequant_pkg::*;
(
  input  logic [7:0] q,
  input  fp32_t      scale,
  input  fp32_t      amax,
  output fp32_t      y
);
  logic [31:0] prod;
  logic [4:0]  lead;
  logic [9:0]  exp_r;
  fp32_t       raw;
  always_comb begin
    prod = {8'd0, 1'b1, scale[22:0]} * {24'd0, q};
    lead = 5'd23;
    for (int i = 24; i < 32; i++) if (prod[i]) lead = 5'(i);
    exp_r = {2'b00, scale[30:23]} + 10'(lead) - 10'd23;
    raw = (scale[30:23] == 8'd0) ? {scale[31], 31'd0} :
          (exp_r >= 10'd255) ? {scale[31], 8'hFF, 23'd0} :
          {scale[31], exp_r[7:0], 23'(prod >> (lead - 5'd23))};
    y = (!amax[31] && amax[30:0] != 31'd0 && raw[30:0] > amax[30:0]) ? {raw[31], amax[30:0]} : raw;
  end
endmodule

// File: rtl/dequant_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] win
);
  logic hit;
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        win = W'((int'(ptr) + i) % N);
        hit = 1'b1;
      end
    gnt = hit ? N'(1) << win : '0;
  end
endmodule

// File: rtl/dequant_sched.sv
// dequant_sched: round-robin sharing of one dequant datapath, lanes serialised to a tagged fp32 stream
module dequant_sched
  import dequant_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LANES   = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [ID_W-1:0]            cfg_id,
  input  logic [31:0]                cfg_scale,
  input  logic [31:0]                cfg_amax,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8*LANES-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_last,
  output logic                       busy
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  state_e             state;
  logic [ID_W-1:0]    ptr, win, cur_id;
  logic [NUM_REQ-1:0] gnt;
  logic [8*LANES-1:0] word;
  logic [CW-1:0]      cnt;
  fp32_t              scale [NUM_REQ];
  fp32_t              amax [NUM_REQ];
  fp32_t              cur_scale, cur_amax, dq;
  logic [7:0]         lane;
  logic               adv, last, own_cfg;
  rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (.req(req_valid), .ptr(ptr), .gnt(gnt), .win(win));
  dequant u_dq (.q(lane), .scale(cur_scale), .amax(cur_amax), .y(dq));
  assign lane      = word[int'(cnt)*8 +: 8];
  assign last      = cnt == CW'(LANES - 1);
  assign adv       = !out_valid || out_ready;
  assign own_cfg   = cfg_we && cfg_id == win;
  assign req_ready = (state == GRANT) ? gnt : '0;
  assign busy      = state != IDLE || out_valid;
  // In-flight words run on their latched scale/amax, so owner writes take effect from the next word.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        scale[i] <= FP32_ONE;
        amax[i]  <= FP32_ZERO;
      end
    end else if (cfg_we && int'(cfg_id) < NUM_REQ) begin
      scale[cfg_id] <= cfg_scale;
      amax[cfg_id]  <= cfg_amax;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      word      <= '0;
      cnt       <= '0;
      cur_scale <= FP32_ZERO;
      cur_amax  <= FP32_ZERO;
      out_valid <= 1'b0;
      out_data  <= FP32_ZERO;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (|req_valid) state <= GRANT;
        GRANT:
          if (|req_valid) begin
            state     <= ISSUE;
            cur_id    <= win;
            ptr       <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            word      <= req_data[int'(win)*8*LANES +: 8*LANES];
            cur_scale <= own_cfg ? cfg_scale : scale[win];
            cur_amax  <= own_cfg ? cfg_amax : amax[win];
            cnt       <= '0;
          end else state <= IDLE;
        ISSUE:
          if (adv) begin
            out_valid <= 1'b1;
            out_data  <= (lane == 8'd0) ? FP32_ZERO : dq;
            out_id    <= cur_id;
            out_last  <= last;
            cnt       <= last ? '0 : cnt + 1'b1;
            if (last) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dequant_sched.sv
// tb_dequant_sched: scoreboard bench for the shared dequant scheduler
module tb_dequant_sched;
  import dequant_pkg::*;
  localparam int NR = 2, L = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [0:0] cfg_id = 1'b0;
  logic [31:0] cfg_scale = '0, cfg_amax = '0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*8*L-1:0] req_data = '0;
  logic out_valid, out_ready = 1'b1, out_last, busy;
  logic [31:0] out_data;
  logic [0:0] out_id;
  logic [2:0] req_valid3 = '0, req_ready3;
  logic [95:0] req_data3 = '0;
  logic out_valid3, out_last3, busy3;
  logic [31:0] out_data3;
  logic [1:0] out_id3;
  int total = 0, bad = 0;
  typedef struct packed {logic [31:0] d; logic [0:0] id; logic last;} exp_t;
  exp_t sb[$];
  exp_t e;
  int gnt_log[$];
  logic [31:0] mscale [NR];

  always #5 clk = ~clk;

  dequant_sched #(.NUM_REQ(NR), .LANES(L)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_scale(cfg_scale), .cfg_amax(cfg_amax),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .out_last(out_last), .busy(busy));

  dequant_sched #(.NUM_REQ(3), .LANES(L)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(1'b0), .cfg_id(2'd0), .cfg_scale(32'h0), .cfg_amax(32'h0),
    .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3), .out_valid(out_valid3),
    .out_ready(1'b1), .out_data(out_data3), .out_id(out_id3), .out_last(out_last3), .busy(busy3));

  // Reference: exact int8 -> fp32 conversion, then scale applied as a power-of-two exponent shift.
  function automatic logic [31:0] fexp(input logic [7:0] q, input logic [31:0] s);
    int p = 0;
    if (q == 8'd0) return 32'h0;
    for (int i = 0; i < 8; i++) if (q[i]) p = i;
    return {s[31], 8'(int'(s[30:23]) + p), 23'({15'd0, q} << (23 - p))};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        total++;
        if (!$onehot(req_ready)) begin bad++; $display("FAIL ready_onehot got %b need one-hot", req_ready); end
      end
      for (int i = 0; i < NR; i++) if (req_ready[i]) begin
        gnt_log.push_back(i);
        for (int k = 0; k < L; k++)
          sb.push_back({fexp(req_data[(i*L+k)*8 +: 8], mscale[i]), 1'(i), k == L - 1});
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL out_unexpected got data=%h id=%0d last=%0b need nothing", out_data, out_id, out_last);
        end else begin
          e = sb.pop_front();
          if ({out_data, out_id, out_last} !== e) begin
            bad++; $display("FAIL out_lane got data=%h id=%0d last=%0b need data=%h id=%0d last=%0b",
                            out_data, out_id, out_last, e.d, e.id, e.last);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_valid3 = '0; out_ready = 1'b1; cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete(); gnt_log.delete();
    for (int i = 0; i < NR; i++) mscale[i] = FP32_ONE;
  endtask

  task automatic send(input int id, input int n, input logic [31:0] w0, input logic [31:0] w1);
    int t;
    @(posedge clk); #1;
    for (int j = 0; j < n; j++) begin
      req_data[id*8*L +: 8*L] = (j == 0) ? w0 : w1;
      req_valid[id] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!req_ready[id] && t < 60);
      if (!req_ready[id]) begin total++; bad++; $display("FAIL grant_timeout got no req_ready need id=%0d", id); end
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    do begin @(negedge clk); t++; end while ((busy || req_valid != '0) && t < 200);
    total++;
    if (busy || sb.size() != 0) begin
      bad++; $display("FAIL %s_drain got busy=%0b pending=%0d need 0", tag, busy, sb.size());
    end
  endtask

  task automatic wait_out(input string tag);
    int t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 50);
    if (!out_valid) begin total++; bad++; $display("FAIL %s_timeout got no out_valid need 1", tag); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 4;
    if ({req_ready, out_valid, out_last, busy} !== '0) begin
      bad++; $display("FAIL reset_ctl got ready=%b v=%0b l=%0b busy=%0b need 0", req_ready, out_valid, out_last, busy);
    end
    if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got %h need 0", out_data); end
    if (out_id !== 1'b0) begin bad++; $display("FAIL reset_id got %0d need 0", out_id); end
    if ({req_ready3, out_valid3, out_data3, out_id3, out_last3, busy3} !== '0) begin
      bad++; $display("FAIL reset_dut3 got v=%0b data=%h need 0", out_valid3, out_data3);
    end
  endtask

  task automatic test_single();
    int t = 0;
    do_reset();
    fork send(0, 1, 32'h04020100, 32'h0); join_none
    do begin @(negedge clk); t++; end while (!req_ready[0] && t < 20);
    repeat (2) @(negedge clk);
    for (int k = 0; k < L; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_last !== (k == L - 1) || out_id !== 1'b0) begin
        bad++; $display("FAIL single_timing lane %0d got v=%0b l=%0b id=%0d need v=1 l=%0b id=0",
                        k, out_valid, out_last, out_id, k == L - 1);
      end
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_after got out_valid=%0b need 0", out_valid); end
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      send(0, 2, 32'h01020304, 32'h05060708);
      send(1, 2, 32'h10203040, 32'h0000FF11);
    join
    wait_idle("b2b");
    total++;
    if (gnt_log.size() != 4) begin bad++; $display("FAIL b2b_count got %0d grants need 4", gnt_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (gnt_log[i] != i % 2) begin bad++; $display("FAIL b2b_order grant %0d got %0d need %0d", i, gnt_log[i], i % 2); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fork send(0, 1, 32'h10080603, 32'h0); join_none
    wait_out("stall");
    @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_id, out_last} !== {1'b1, 32'h41000000, 1'b0, 1'b0}) begin
        bad++; $display("FAIL stall_hold cycle %0d got v=%0b data=%h id=%0d l=%0b need v=1 data=41000000 id=0 l=0",
                        i, out_valid, out_data, out_id, out_last);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle("stall");
  endtask

  task automatic test_cfg_defer();
    do_reset();
    fork send(1, 1, 32'h08040201, 32'h0); join_none
    wait_out("cfg");
    @(posedge clk); #1 cfg_we = 1'b1; cfg_id = 1'b1; cfg_scale = 32'h40000000; mscale[1] = 32'h40000000;
    @(posedge clk); #1 cfg_id = 1'b0; cfg_scale = 32'h3F000000; mscale[0] = 32'h3F000000;
    @(posedge clk); #1 cfg_we = 1'b0;
    wait_idle("cfg_old");
    send(1, 1, 32'h04020100, 32'h0);
    wait_idle("cfg_new1");
    send(0, 1, 32'h04020100, 32'h0);
    wait_idle("cfg_new0");
  endtask

  task automatic test_async_rst();
    do_reset();
    send(0, 1, 32'h08040201, 32'h0);
    wait_out("arst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total += 2;
    if ({out_valid, busy, out_last, req_ready} !== '0) begin
      bad++; $display("FAIL arst_ctl got v=%0b busy=%0b l=%0b need 0", out_valid, busy, out_last);
    end
    if (out_data !== 32'h0) begin bad++; $display("FAIL arst_data got %h need 0", out_data); end
    sb.delete(); gnt_log.delete();
    for (int i = 0; i < NR; i++) mscale[i] = FP32_ONE;
    @(posedge clk); #3 rst = 1'b0;
    fork
      send(0, 1, 32'h01010101, 32'h0);
      send(1, 1, 32'h02020202, 32'h0);
    join
    wait_idle("arst");
    total++;
    if (gnt_log.size() == 0 || gnt_log[0] != 0) begin
      bad++; $display("FAIL arst_ptr got first grant %0d need 0", gnt_log.size() ? gnt_log[0] : -1);
    end
  endtask

  task automatic test_wrap3();
    int t = 0;
    do_reset();
    @(posedge clk); #1 req_data3 = 96'h00000305_00000000_00000000; req_valid3 = 3'b100;
    @(negedge clk);
    total++;
    if (req_ready3 !== 3'b000) begin bad++; $display("FAIL wrap_idle got %b need 000", req_ready3); end
    @(negedge clk);
    total++;
    if (req_ready3 !== 3'b100) begin bad++; $display("FAIL wrap_grant2 got %b need 100", req_ready3); end
    @(posedge clk); #1 req_valid3 = '0;
    do begin @(negedge clk); t++; end while (!out_valid3 && t < 20);
    total++;
    if ({out_valid3, out_id3, out_data3} !== {1'b1, 2'd2, 32'h40A00000}) begin
      bad++; $display("FAIL wrap_out got v=%0b id=%0d data=%h need v=1 id=2 data=40a00000", out_valid3, out_id3, out_data3);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (busy3 && t < 20);
    @(posedge clk); #1 req_valid3 = 3'b111;
    t = 0;
    do begin @(negedge clk); t++; end while (req_ready3 == '0 && t < 20);
    total++;
    if (req_ready3 !== 3'b001) begin bad++; $display("FAIL wrap_ptr got %b need 001", req_ready3); end
    @(posedge clk); #1 req_valid3 = '0;
    t = 0;
    do begin @(negedge clk); t++; end while (busy3 && t < 20);
    total++;
    if (busy3 !== 1'b0) begin bad++; $display("FAIL wrap_drain got busy=%0b need 0", busy3); end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mscale[i] = FP32_ONE;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_cfg_defer();
    test_async_rst();
    test_wrap3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
